// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx - I2S serial receiver with stereo-pair output and ready/valid handoff
//
// The I2S bus (i_bck, i_lrck, i_sdin) is asynchronous to i_clk. It is only
// oversampled and never used as a clock. i_clk must run at least 4x i_bck.
// Each channel period opens with a word-select change. The bit sampled on
// that change is discarded. The next WORD_SIZE bits form the word, MSB
// first. Any further bits in the period are ignored. A left word followed
// by a right word in the next period forms a pair, and the pair is
// presented on the output registers.
//
// Parameters
//   WORD_SIZE  bits per channel word (8..32)
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_bck        I2S bit clock (sampled)
//   i_lrck       I2S word select, 0 = left, 1 = right (sampled)
//   i_sdin       I2S serial data (sampled)
//   o_l_data     left sample of the presented pair
//   o_r_data     right sample of the presented pair
//   o_valid      presented pair is valid
//   i_ready      consumer accepts the pair when o_valid is high
//   o_overrun    sticky flag: a pair was overwritten before transfer
//   i_ovr_clr    clears o_overrun
//
// Build option
//   I2S_RX_OVERRUN_FLAG_EN  when defined, o_overrun is a sticky flag that is
//                           cleared by i_ovr_clr. When undefined, o_overrun
//                           is tied to 0 and i_ovr_clr is ignored.
//
// Capture FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_SYNC  | no word-select change seen since reset; nothing captured
//   ST_SHIFT | shifting word bits, bit count < WORD_SIZE
//   ST_IDLE  | word complete, ignoring bits until next word-select change
// ---------------------------------------------------------------------------
module i2s_rx #(
    parameter int WORD_SIZE = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_bck,
    input  logic                 i_lrck,
    input  logic                 i_sdin,
    output logic [WORD_SIZE-1:0] o_l_data,
    output logic [WORD_SIZE-1:0] o_r_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overrun,
    input  logic                 i_ovr_clr
);

    localparam int CNT_W = $clog2(WORD_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    // bit0: first flop, bit1: synchronized value, bit2 (bck only): previous
    logic [2:0] bck_sync_q;
    logic [1:0] lrck_sync_q;
    logic [1:0] sdin_sync_q;

    logic bck_s, bck_prev, lrck_s, sdin_s;
    logic strobe;
    logic ws_change;

    state_t state_q, state_d;
    logic   shift_en;
    logic   word_done;

    logic                 have_prev_q;
    logic                 lrck_prev_q;
    logic                 chan_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [WORD_SIZE-2:0] word_q;
    logic [WORD_SIZE-1:0] word_full;
    logic [WORD_SIZE-1:0] l_hold_q;
    logic                 left_ok_q;
    logic                 pair_done;

    logic [WORD_SIZE-1:0] l_data_q, r_data_q;
    logic                 valid_q, valid_d;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bck_sync_q  <= '0;
            lrck_sync_q <= '0;
            sdin_sync_q <= '0;
        end else begin
            bck_sync_q  <= {bck_sync_q[1:0], i_bck};
            lrck_sync_q <= {lrck_sync_q[0], i_lrck};
            sdin_sync_q <= {sdin_sync_q[0], i_sdin};
        end
    end

    assign bck_s    = bck_sync_q[1];
    assign bck_prev = bck_sync_q[2];
    assign lrck_s   = lrck_sync_q[1];
    assign sdin_s   = sdin_sync_q[1];
    assign strobe   = bck_s & ~bck_prev;

    // The first strobe after reset has nothing to compare against. It only
    // records lrck, so capture always starts at a real word-select edge.
    assign ws_change = strobe & have_prev_q & (lrck_s != lrck_prev_q);

    // ------------------------------------------------------------------
    // Capture FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (ws_change) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ws_change) begin
                    state_d = ST_SHIFT;
                end else if (strobe && (bit_cnt_q == CNT_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ws_change) state_d = ST_SHIFT;
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        shift_en  = 1'b0;
        word_done = 1'b0;
        if ((state_q == ST_SHIFT) && strobe && !ws_change) begin
            shift_en  = 1'b1;
            word_done = (bit_cnt_q == CNT_LAST);
        end
    end

    // The word register holds only the bits before the current one. The
    // completed word is assembled together with the bit being sampled now,
    // so the pair can be registered on the cycle right after the strobe.
    assign word_full = {word_q, sdin_s};

    // A pair needs a right word whose immediately preceding left period
    // produced a complete word.
    assign pair_done = word_done & chan_q & left_ok_q;

    // ------------------------------------------------------------------
    // Word capture datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            have_prev_q <= 1'b0;
            lrck_prev_q <= 1'b0;
            chan_q      <= 1'b0;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            l_hold_q    <= '0;
            left_ok_q   <= 1'b0;
        end else begin
            if (strobe) begin
                have_prev_q <= 1'b1;
                lrck_prev_q <= lrck_s;
            end

            // Counter stops at WORD_SIZE because shifting ends in ST_IDLE.
            if (ws_change) begin
                chan_q    <= lrck_s;
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end

            if (shift_en) begin
                word_q <= word_full[WORD_SIZE-2:0];
            end

            if (word_done && !chan_q) begin
                l_hold_q <= word_full;
            end

            // A new left period invalidates any earlier left word. A
            // completed pair consumes it.
            if (ws_change && !lrck_s) begin
                left_ok_q <= 1'b0;
            end else if (word_done && !chan_q) begin
                left_ok_q <= 1'b1;
            end else if (pair_done) begin
                left_ok_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output pair and handshake. The right word goes straight into the
    // output register, so that register also serves as the right holding
    // register.
    // ------------------------------------------------------------------
    assign valid_d = pair_done | (valid_q & ~i_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            l_data_q <= '0;
            r_data_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (pair_done) begin
                l_data_q <= l_hold_q;
                r_data_q <= word_full;
            end
        end
    end

    assign o_l_data = l_data_q;
    assign o_r_data = r_data_q;
    assign o_valid  = valid_q;

`ifdef I2S_RX_OVERRUN_FLAG_EN
    logic overrun_q, overrun_d;
    logic overrun_evt;

    // When a set and a clear happen in the same cycle, the set wins.
    assign overrun_evt = pair_done & valid_q & ~i_ready;
    assign overrun_d   = overrun_evt | (overrun_q & ~i_ovr_clr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign o_overrun = overrun_q;
`else
    logic ovr_clr_unused;

    assign ovr_clr_unused = i_ovr_clr;
    assign o_overrun      = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

    localparam int WS = 24;
    localparam logic [31:0] MASK = 32'((64'd1 << WS) - 64'd1);

`ifdef I2S_RX_OVERRUN_FLAG_EN
    localparam logic [31:0] OVR_EXP = 32'd1;
`else
    localparam logic [31:0] OVR_EXP = 32'd0;
`endif

    logic          i_clk;
    logic          i_rst_n;
    logic          i_bck;
    logic          i_lrck;
    logic          i_sdin;
    logic [WS-1:0] o_l_data;
    logic [WS-1:0] o_r_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_overrun;
    logic          i_ovr_clr;

    i2s_rx #(.WORD_SIZE(WS)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_bck     (i_bck),
        .i_lrck    (i_lrck),
        .i_sdin    (i_sdin),
        .o_l_data  (o_l_data),
        .o_r_data  (o_r_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_overrun (o_overrun),
        .i_ovr_clr (i_ovr_clr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected pairs in order, plus the frame-level rules.
    logic [31:0] exp_l_q[$];
    logic [31:0] exp_r_q[$];
    bit seen;      // some bit period has been seen since reset
    bit left_ok;   // previous left period delivered a full word
    bit rand_ready = 1'b0;

    int pe_cnt   = 0;
    int rise_cnt = 0;
    always @(posedge i_clk) pe_cnt <= pe_cnt + 1;

    // Output monitor
    logic valid_prev = 1'b0;
    logic pw_chk     = 1'b0;
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            valid_prev <= 1'b0;
            pw_chk     <= 1'b0;
        end else begin
            if (pw_chk) check_val("valid_pulse_1cyc", 32'(o_valid), 32'd0);
            if (o_valid && !valid_prev)
                check_val("latency_le4", 32'((pe_cnt - rise_cnt) <= 4), 32'd1);
            if (o_valid && i_ready) begin
                check_val("pair_expected", 32'(exp_l_q.size() != 0), 32'd1);
                if (exp_l_q.size() != 0) begin
                    check_val("l_data", 32'(o_l_data), exp_l_q.pop_front());
                    check_val("r_data", 32'(o_r_data), exp_r_q.pop_front());
                end
                pw_chk <= 1'b1;
            end else begin
                pw_chk <= 1'b0;
            end
            valid_prev <= o_valid;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge i_clk);
        #3;
    endtask

    task automatic send_bit(input logic lr, input logic d, input bit mark);
        i_bck  = 1'b0;
        i_lrck = lr;
        i_sdin = d;
        if (rand_ready) i_ready = ($urandom_range(3) != 0);
        wait_clk(4);
        i_bck = 1'b1;
        if (mark) rise_cnt = pe_cnt;
        if (rand_ready) i_ready = ($urandom_range(3) != 0);
        wait_clk(4);
    endtask

    task automatic mid_reset();
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check_val("rst_valid", 32'(o_valid), 32'd0);
        check_val("rst_l_data", 32'(o_l_data), 32'd0);
        check_val("rst_r_data", 32'(o_r_data), 32'd0);
        check_val("rst_overrun", 32'(o_overrun), 32'd0);
        wait_clk(2);
        i_rst_n = 1'b1;
        exp_l_q.delete();
        exp_r_q.delete();
        seen    = 1'b0;
        left_ok = 1'b0;
    endtask

    // One channel period of len bit clocks. Bit 0 is discarded by the
    // receiver. Bits 1..WS carry the word MSB first. Later bits are padding.
    task automatic send_chan(input logic lr, input logic [31:0] word, input int len, input int rst_bit);
        for (int i = 0; i < len; i++) begin
            logic b;
            if (i == rst_bit) mid_reset();
            if (i >= 1 && i <= WS) b = word[WS - i];
            else b = 1'($urandom_range(1));
            send_bit(lr, b, lr && (i == WS));
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                              input int llen, input int rlen, input int rst_bit);
        left_ok = seen && (llen >= WS + 1);
        send_chan(1'b0, l, llen, -1);
        seen = 1'b1;
        if (left_ok && (rlen >= WS + 1) && (rst_bit < 0)) begin
            exp_l_q.push_back(l & MASK);
            exp_r_q.push_back(r & MASK);
        end
        left_ok = 1'b0;
        send_chan(1'b1, r, rlen, rst_bit);
        seen = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ol, orr;
        i_rst_n   = 1'b0;
        i_bck     = 1'b0;
        i_lrck    = 1'b0;
        i_sdin    = 1'b0;
        i_ready   = 1'b1;
        i_ovr_clr = 1'b0;
        seen      = 1'b0;
        left_ok   = 1'b0;
        wait_clk(3);
        @(negedge i_clk);
        check_val("reset_valid", 32'(o_valid), 32'd0);
        check_val("reset_l_data", 32'(o_l_data), 32'd0);
        check_val("reset_r_data", 32'(o_r_data), 32'd0);
        check_val("reset_overrun", 32'(o_overrun), 32'd0);
        wait_clk(1);
        i_rst_n = 1'b1;
        wait_clk(2);

        // Counting data; frame 0 carries no captured left word and is dropped
        for (int f = 0; f < 16; f++)
            send_frame(32'(2 * f), 32'(2 * f + 1), 32, 32, -1);
        check_val("no_overrun_b2b", 32'(o_overrun), 32'd0);

        for (int f = 0; f < 3; f++)
            send_frame(32'hA5A5A5, 32'h5A5A5A, 32, 32, -1);

        // Random data, random period lengths, random ready
        rand_ready = 1'b1;
        for (int f = 0; f < 12; f++)
            send_frame($urandom, $urandom, $urandom_range(32, WS + 1), $urandom_range(32, WS + 1), -1);
        rand_ready = 1'b0;
        i_ready    = 1'b1;
        wait_clk(4);

        // Short left word: that frame is dropped and the next ones are received
        send_frame($urandom, $urandom, 11, 32, -1);
        send_frame($urandom, $urandom, 32, 32, -1);
        send_frame($urandom, $urandom, 32, 32, -1);

        // Consumer stalls for 3 frames
        wait_clk(2);
        i_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            ol  = $urandom;
            orr = $urandom;
            send_frame(ol, orr, 32, 32, -1);
        end
        @(negedge i_clk);
        check_val("ovr_valid_held", 32'(o_valid), 32'd1);
        check_val("ovr_l_last", 32'(o_l_data), ol & MASK);
        check_val("ovr_r_last", 32'(o_r_data), orr & MASK);
        check_val("ovr_flag_set", 32'(o_overrun), OVR_EXP);
        while (exp_l_q.size() > 1) begin
            void'(exp_l_q.pop_front());
            void'(exp_r_q.pop_front());
        end
        @(posedge i_clk);
        #3;
        i_ready = 1'b1;
        wait_clk(3);
        check_val("ovr_flag_sticky", 32'(o_overrun), OVR_EXP);
        i_ovr_clr = 1'b1;
        wait_clk(1);
        i_ovr_clr = 1'b0;
        @(negedge i_clk);
        check_val("ovr_flag_cleared", 32'(o_overrun), 32'd0);
        @(posedge i_clk);
        #3;

        // Reset mid right word, then recovery
        send_frame($urandom, $urandom, 32, 32, 12);
        for (int f = 0; f < 3; f++)
            send_frame($urandom, $urandom, 32, 32, -1);

        wait_clk(20);
        check_val("all_pairs_received", 32'(exp_l_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
